// File: rtl/booth_seq_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state
// encoding, ALU opcode for MUL, default datapath width and the recoding
// step size.
// Build option: BOOTH_RADIX4_EN selects radix-4 recoding (two multiplier
// bits retired per cycle) instead of the default radix-2 recoding.
package booth_seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // ALU opcode whose result the Z register takes from this unit.
  localparam logic [3:0] ALU_OP_MUL = 4'd11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

`ifdef BOOTH_RADIX4_EN
  localparam int RADIX_SHIFT = 2;
`else
  localparam int RADIX_SHIFT = 1;
`endif

  // Booth window: the retired multiplier bits plus the previous bit.
  localparam int BOOTH_BITS = RADIX_SHIFT + 1;

  // Number of RUN cycles needed to retire all multiplier bits.
  function automatic int iter_total(input int width);
    return width / RADIX_SHIFT;
  endfunction

endpackage : booth_seq_multiplier_pkg

// File: rtl/booth_seq_multiplier_if.sv
// Start/done handshake plus operand and product buses between the control
// unit (master) and the Booth multiplier (slave).
// Build option: BOOTH_RADIX4_EN does not change this interface.
interface booth_seq_multiplier_if
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface : booth_seq_multiplier_if

// File: rtl/booth_seq_multiplier_recoder.sv
// Combinational Booth recoder: turns the current Booth window into the
// signed addend applied to the accumulator this cycle.
// Build option: BOOTH_RADIX4_EN widens the window to three bits and adds
// the +-2M digits.
module booth_seq_multiplier_recoder
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [BOOTH_BITS-1:0] booth_bits_i,
  input  logic [WIDTH+1:0]      m_i,
  output logic [WIDTH+1:0]      addend_o
);

`ifdef BOOTH_RADIX4_EN
  logic [WIDTH+1:0] m2;

  // M is sign-extended by two bits, so doubling cannot lose the sign.
  assign m2 = m_i << 1;

  // Radix-4 digit select from {Q[1], Q[0], Q_1}.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    addend_o = '0;
    case (booth_bits_i)
      3'b001, 3'b010: addend_o = m_i;
      3'b011:         addend_o = m2;
      3'b100:         addend_o = -m2;
      3'b101, 3'b110: addend_o = -m_i;
      default:        addend_o = '0;
    endcase
  end
`else
  // Radix-2 digit select from {Q[0], Q_1}.
  always_comb begin
    addend_o = '0;
    case (booth_bits_i)
      2'b01:   addend_o = m_i;
      2'b10:   addend_o = -m_i;
      default: addend_o = '0;
    endcase
  end
`endif

endmodule : booth_seq_multiplier_recoder

// File: rtl/booth_seq_multiplier.sv
// Multi-cycle signed Booth multiplier for the ALU MUL operation. The
// control unit pulses start in IDLE, stalls while busy, and takes the
// 2*WIDTH-bit product when done pulses. WIDTH must be even.
// Build option: BOOTH_RADIX4_EN halves the iteration count via radix-4
// recoding; ports, handshake and results are identical in both builds.
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clock,
  input  logic                   clear,
  booth_seq_multiplier_if.slave  bus
);

  // Accumulator carries two guard bits so M = -2^(WIDTH-1) (and 2M in the
  // radix-4 build) never overflows it.
  localparam int AW    = WIDTH + 2;
  localparam int ITERS = iter_total(WIDTH);
  localparam int CW    = $clog2(ITERS + 1);

  mul_state_e         state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [AW-1:0]      m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [AW-1:0]          addend;
  logic [AW-1:0]          sum;
  logic signed [AW+WIDTH:0] shifted;

  booth_seq_multiplier_recoder #(
    .WIDTH (WIDTH)
  ) u_recoder (
    .booth_bits_i ({q_q[RADIX_SHIFT-1:0], q1_q}),
    .m_i          (m_q),
    .addend_o     (addend)
  );

  // Add the recoded digit, then arithmetic-shift {A, Q, Q_1} one step.
  assign sum     = a_q + addend;
  assign shifted = $signed({sum, q_q, q1_q}) >>> RADIX_SHIFT;

  // FSM next state: accept in IDLE, iterate in RUN, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (bus.start) state_d = MUL_RUN;
      MUL_RUN:  if (cnt_q == '0) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // Datapath next state: load operands on accept, iterate while the
  // count is nonzero, capture the product on the DONE-entry edge.
  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      MUL_IDLE: begin
        if (bus.start) begin
          a_d   = '0;
          q_d   = bus.multiplier;
          q1_d  = 1'b0;
          m_d   = {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
          cnt_d = CW'(ITERS);
        end
      end
      MUL_RUN: begin
        if (cnt_q != '0) begin
          {a_d, q_d, q1_d} = shifted;
          cnt_d            = cnt_q - CW'(1);
        end else begin
          product_d = {a_q[WIDTH-1:0], q_q};
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    // Clear also zeroes the datapath, not just the FSM, so a cleared unit
    // presents a zero product and starts from a known accumulator.
    if (clear) begin
      state_q   <= MUL_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q != MUL_IDLE);
  assign bus.done    = (state_q == MUL_DONE);
  assign bus.product = product_q;

endmodule : booth_seq_multiplier

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: directed cases plus
// randomized traffic, checked by a scoreboard fed from a cycle-level
// reference model of the handshake and plain signed multiplication.
module tb_booth_seq_multiplier;

  localparam int W = 32;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = W / 2 + 1;
`else
  localparam int LAT = W + 1;
`endif

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  booth_seq_multiplier_if #(.WIDTH(W)) bus ();

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint a;
    longint b;
    a = $signed(m);
    b = $signed(q);
    return 64'(a * b);
  endfunction

  typedef struct {
    logic [63:0] prod;
    int          done_edge;
  } exp_t;

  exp_t        sb[$];
  int          free_edge  = 0;
  int          busy_last  = -1;
  logic [63:0] hold_prod  = '0;
  bit          model_live = 1'b0;

  // Reference model: decides which starts are accepted and when each
  // result is due, from the handshake timing rules alone.
  always @(posedge clock) begin
    cycle++;
    if (clear) begin
      sb.delete();
      free_edge  = cycle + 1;
      busy_last  = -1;
      hold_prod  = '0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (sb.size() > 0 && sb[0].done_edge == cycle) hold_prod = sb[0].prod;
      if (bus.start && cycle >= free_edge) begin
        sb.push_back('{prod: ref_mul(bus.multiplicand, bus.multiplier), done_edge: cycle + LAT});
        free_edge = cycle + LAT + 2;
        busy_last = cycle + LAT;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the edge.
  always @(negedge clock) begin
    exp_t e;
    if (model_live) begin
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("done_edge", 64'(cycle), 64'(e.done_edge));
          check("product_at_done", bus.product, e.prod);
        end
      end else if (sb.size() > 0 && sb[0].done_edge <= cycle) begin
        e = sb.pop_front();
        check("done_missing", 64'(bus.done), 64'd1);
      end
      check("busy", 64'(bus.busy), 64'(cycle <= busy_last));
      check("product_hold", bus.product, hold_prod);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic issue(input logic [31:0] m, input logic [31:0] q);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    tick();
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
  endtask

  task automatic run_one(input logic [31:0] m, input logic [31:0] q);
    issue(m, q);
    wait_idle(LAT + 5);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    tick(2);
    clear = 1'b0;
    check("reset_product", bus.product, 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);

    // Small positive operands.
    run_one(32'h0000_0054, 32'h0000_0006);
    check("t1_product", bus.product, 64'h0000_0000_0000_01F8);

    // Negative multiplicand.
    run_one(32'hFFFF_FFFD, 32'h0000_0007);
    check("t2_product", bus.product, 64'hFFFF_FFFF_FFFF_FFEB);

    // Corner operands.
    run_one(32'h8000_0000, 32'h8000_0000);
    check("t3_min_min", bus.product, 64'h4000_0000_0000_0000);
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("t3_m1_m1", bus.product, 64'h0000_0000_0000_0001);

    // Start pulsed mid-RUN with other operands is ignored.
    issue(32'h0000_1234, 32'hFFFF_FFAB);
    tick(5);
    bus.start        = 1'b1;
    bus.multiplicand = 32'h0000_0099;
    bus.multiplier   = 32'h0000_0077;
    tick();
    bus.start = 1'b0;
    wait_idle(LAT + 5);
    check("t4_ignored_start", bus.product, 64'hFFFF_FFFF_FFF9_F4BC);
    tick();

    // Clear mid-RUN aborts with no done pulse; a new start still works.
    issue(32'h0000_0007, 32'h0000_0009);
    tick(9);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_done", 64'(bus.done), 64'd0);
    check("t5_product", bus.product, 64'd0);
    tick(LAT + 3);
    run_one(32'hFFED_2979, 32'h0000_0059);
    tick();

    // Start held high across two results.
    bus.start        = 1'b1;
    bus.multiplicand = 32'd11;
    bus.multiplier   = 32'd13;
    tick();
    bus.multiplicand = 32'hFFFF_FFFB;
    bus.multiplier   = 32'd6;
    tick(LAT + 2);
    bus.start = 1'b0;
    wait_idle(LAT + 5);
    check("t6_second_product", bus.product, 64'hFFFF_FFFF_FFFF_FFE2);
    tick();

    // Randomized traffic: gaps, stray starts while busy, held starts, clears.
    for (int i = 0; i < 60; i++) begin
      case ($urandom % 5)
        0: begin
          bus.start = 1'b1;
          for (int k = 0; k < int'($urandom_range(LAT, 2 * LAT + 4)); k++) begin
            bus.multiplicand = pick();
            bus.multiplier   = pick();
            tick();
          end
          bus.start = 1'b0;
        end
        1: begin
          issue(pick(), pick());
          tick($urandom_range(1, LAT - 1));
          bus.start        = 1'b1;
          bus.multiplicand = $urandom;
          bus.multiplier   = $urandom;
          tick();
          bus.start = 1'b0;
        end
        2: begin
          issue(pick(), pick());
          if ($urandom % 4 == 0) begin
            tick($urandom_range(0, LAT));
            clear = 1'b1;
            tick();
            clear = 1'b0;
          end
        end
        default: issue(pick(), pick());
      endcase
      wait_idle(2 * LAT + 10);
      tick($urandom_range(0, 3));
    end

    tick(3);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_booth_seq_multiplier
